// File: rtl/rvx_alu_mc.sv
// rvx_alu_mc -- multi-cycle execution unit for the RVX10 custom-instruction
// group, sitting in EX beside the base ALU.
//
// Decodes {funct7_2b, funct3} locally. Logic ops, signed/unsigned min/max and
// abs complete in one cycle. Rotates walk the working register ROT_STEP bits
// per cycle through the ROT state, unless RVX_FAST_ROT_EN is defined, in which
// case a full barrel rotator makes them single-cycle and ROT is never entered.
//
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   flush                 kills any in-flight or held operation
//   in_valid / in_ready   operation handshake (funct7_2b, funct3, a, b)
//   out_valid / out_ready result handshake (result, illegal)
//   busy                  EX stall request: rotating, or result not yet taken
//
// Build option: RVX_FAST_ROT_EN (single-cycle rotates).

module rvx_alu_mc #(
    parameter int XLEN     = 32,
    parameter int ROT_STEP = 1
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      funct7_2b,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            illegal,
    output logic            busy
);

    localparam int SW = $clog2(XLEN);
    localparam logic [SW-1:0] STEP = ROT_STEP[SW-1:0];

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ROT  = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;

    // Shift amount is an int so s==0 yields x (x >> XLEN is all zeros).
    function automatic logic [XLEN-1:0] rotl(input logic [XLEN-1:0] x, input int s);
        return (x << s) | (x >> (XLEN - s));
    endfunction

    function automatic logic [XLEN-1:0] rotr(input logic [XLEN-1:0] x, input int s);
        return (x >> s) | (x << (XLEN - s));
    endfunction

    logic [1:0]      state;
    logic [XLEN-1:0] work;
    logic [XLEN-1:0] res_q;
    logic            ill_q;
    logic            dir_q;   // 1 = rotate right
    logic [SW-1:0]   rem;

    logic [4:0]      op;
    logic [SW-1:0]   shamt;
    logic            is_rot;
    logic            go_rot;
    logic            accept;
    logic [XLEN-1:0] res_c;
    logic            ill_c;
    logic [SW-1:0]   step;
    logic [XLEN-1:0] work_nx;

    assign op     = {funct7_2b, funct3};
    assign shamt  = b[SW-1:0];
    assign is_rot = (op == 5'b10_000) || (op == 5'b10_001);

`ifdef RVX_FAST_ROT_EN
    assign go_rot = 1'b0;
`else
    assign go_rot = is_rot && (shamt != '0);
`endif

    // Flush and reset both mask in_ready so nothing is taken in those cycles.
    assign in_ready  = reset_n && !flush &&
                       ((state == S_IDLE) || ((state == S_HOLD) && out_ready));
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == S_HOLD);
    assign busy      = (state == S_ROT) || (out_valid && !out_ready);
    assign result    = res_q;
    assign illegal   = ill_q;

    // Single-cycle datapath. In the iterative build a rotate only reaches here
    // with shamt==0, where the answer is a itself.
    always_comb begin
        res_c = '0;
        ill_c = 1'b0;
        case (op)
            5'b00_000: res_c = a & ~b;
            5'b00_001: res_c = a | ~b;
            5'b00_010: res_c = a ^ ~b;
            5'b01_000: res_c = ($signed(a) < $signed(b)) ? a : b;
            5'b01_001: res_c = ($signed(a) > $signed(b)) ? a : b;
            5'b01_010: res_c = (a < b) ? a : b;
            5'b01_011: res_c = (a > b) ? a : b;
`ifdef RVX_FAST_ROT_EN
            5'b10_000: res_c = rotl(a, int'(shamt));
            5'b10_001: res_c = rotr(a, int'(shamt));
`else
            5'b10_000: res_c = a;
            5'b10_001: res_c = a;
`endif
            5'b11_000: res_c = a[XLEN-1] ? ('0 - a) : a;  // most-negative wraps to itself
            default:   ill_c = 1'b1;
        endcase
    end

    // Iterative rotate: the last step may be shorter than ROT_STEP.
    assign step    = (rem < STEP) ? rem : STEP;
    assign work_nx = dir_q ? rotr(work, int'(step)) : rotl(work, int'(step));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= S_IDLE;
            work  <= '0;
            res_q <= '0;
            ill_q <= 1'b0;
            dir_q <= 1'b0;
            rem   <= '0;
        end else if (flush) begin
            state <= S_IDLE;
            rem   <= '0;
        end else begin
            case (state)
                S_IDLE, S_HOLD: begin
                    if (accept) begin
                        if (go_rot) begin
                            state <= S_ROT;
                            work  <= a;
                            rem   <= shamt;
                            dir_q <= funct3[0];
                        end else begin
                            state <= S_HOLD;
                            res_q <= res_c;
                            ill_q <= ill_c;
                        end
                    end else if (out_ready) begin
                        // In HOLD the result was taken; in IDLE this is a no-op.
                        state <= S_IDLE;
                    end
                end
                S_ROT: begin
                    work <= work_nx;
                    rem  <= rem - step;
                    if (rem == step) begin
                        state <= S_HOLD;
                        res_q <= work_nx;
                        ill_q <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rvx_alu_mc.sv
// Testbench for rvx_alu_mc: directed checks for the documented corner cases
// followed by randomized traffic with random backpressure and occasional
// flushes. The driver pushes model results into a queue on accept; a separate
// negedge monitor compares whatever the DUT presents, including its latency.

module tb_rvx_alu_mc;

    localparam int XLEN     = 32;
    localparam int ROT_STEP = 1;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [1:0]      f7 = '0;
    logic [2:0]      f3 = '0;
    logic [XLEN-1:0] a = '0;
    logic [XLEN-1:0] b = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [XLEN-1:0] result;
    logic            illegal;
    logic            busy;

    rvx_alu_mc #(.XLEN(XLEN), .ROT_STEP(ROT_STEP)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .funct7_2b(f7), .funct3(f3), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .illegal(illegal), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [XLEN-1:0] res;
        logic            ill;
        int              due;   // cycle count at which out_valid must first be seen
    } exp_t;

    exp_t q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    bit   presented = 1'b0;
    bit   rand_rdy = 1'b0;
    logic [4:0] tbl [10] = '{5'b00000, 5'b00001, 5'b00010, 5'b01000, 5'b01001,
                             5'b01010, 5'b01011, 5'b10000, 5'b10001, 5'b11000};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic bound_fail(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: bound expired (cycle %0d)", nm, cyc);
    endtask

    // Reference model: {illegal, result} from the opcode table.
    function automatic logic [XLEN:0] model(input logic [1:0] fa, input logic [2:0] fb,
                                            input logic [XLEN-1:0] x, input logic [XLEN-1:0] y);
        int sx, sy, sh;
        logic [XLEN-1:0] r;
        logic ill;
        sx = x; sy = y; sh = int'(y % XLEN);
        r = '0; ill = 1'b0;
        case ({fa, fb})
            5'b00000: r = x & ~y;
            5'b00001: r = x | ~y;
            5'b00010: r = ~(x ^ y);
            5'b01000: r = (sx < sy) ? x : y;
            5'b01001: r = (sx < sy) ? y : x;
            5'b01010: r = (x < y) ? x : y;
            5'b01011: r = (x < y) ? y : x;
            5'b10000: for (int i = 0; i < XLEN; i++) r[(i + sh) % XLEN] = x[i];
            5'b10001: for (int i = 0; i < XLEN; i++) r[i] = x[(i + sh) % XLEN];
            5'b11000: r = (sx < 0) ? 32'(-sx) : x;
            default:  ill = 1'b1;
        endcase
        return {ill, r};
    endfunction

    function automatic int lat(input logic [1:0] fa, input logic [2:0] fb, input logic [XLEN-1:0] y);
        int sh;
        sh = int'(y % XLEN);
`ifdef RVX_FAST_ROT_EN
        return 1;
`else
        if (fa == 2'b10 && fb[2:1] == 2'b00 && sh != 0)
            return 1 + (sh + ROT_STEP - 1) / ROT_STEP;
        return 1;
`endif
    endfunction

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    // Offer one op, wait (bounded) for acceptance and queue its expectation.
    task automatic issue(input logic [1:0] fa, input logic [2:0] fb,
                         input logic [XLEN-1:0] x, input logic [XLEN-1:0] y);
        logic [XLEN:0] m;
        f7 = fa; f3 = fb; a = x; b = y; in_valid = 1'b1;
        for (int t = 0; t < 200; t++) begin
            @(negedge clk);
            if (in_ready) begin
                m = model(fa, fb, x, y);
                q.push_back('{m[XLEN-1:0], m[XLEN], cyc + lat(fa, fb, y)});
                step();
                in_valid = 1'b0;
                a = $urandom; b = $urandom;   // operands must have been captured
                return;
            end
            step();
        end
        in_valid = 1'b0;
        bound_fail("accept_timeout");
    endtask

    task automatic do_flush();
        flush = 1'b1;
        q.delete();
        step();
        flush = 1'b0;
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (!reset_n || flush) begin
            presented = 1'b0;
        end else if (out_valid) begin
            if (q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_out_valid: got result 0x%0h, expected no output (cycle %0d)", result, cyc);
            end else begin
                if (!presented) begin
                    chk("latency", cyc, q[0].due);
                    presented = 1'b1;
                end
                chk("result", result, q[0].res);
                chk("illegal", 32'(illegal), 32'(q[0].ill));
                if (out_ready) begin
                    void'(q.pop_front());
                    presented = 1'b0;
                end
            end
        end else if (q.size() > 0 && cyc > q[0].due) begin
            n_chk++;
            n_fail++;
            $display("FAIL late_out_valid: got none by cycle %0d, expected by cycle %0d", cyc, q[0].due);
        end
    end

    task automatic single(input logic [1:0] fa, input logic [2:0] fb, input logic [XLEN-1:0] x,
                          input logic [XLEN-1:0] y, input logic [XLEN-1:0] er, input logic ei);
        issue(fa, fb, x, y);
        @(negedge clk);
        chk("dir_out_valid", 32'(out_valid), 32'd1);
        chk("dir_result", result, er);
        chk("dir_illegal", 32'(illegal), 32'(ei));
        step();
    endtask

    initial begin
        int idx;
        logic [4:0] code;
        logic [XLEN-1:0] rb;

        // Reset
        reset_n = 1'b0; out_ready = 1'b1;
        step(); step();
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd0);
        step();
        reset_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        step();

        // Single-cycle ops from the plan
        single(2'b00, 3'b000, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'h00F0_00F0, 1'b0);
        single(2'b01, 3'b000, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFF, 1'b0);
        single(2'b01, 3'b010, 32'hFFFF_FFFF, 32'h1, 32'h0000_0001, 1'b0);
        single(2'b11, 3'b000, 32'h8000_0000, 32'h0, 32'h8000_0000, 1'b0);
        single(2'b10, 3'b010, 32'h1234_5678, 32'h9abc_def0, 32'h0, 1'b1);
        single(2'b10, 3'b001, 32'hCAFE_BABE, 32'h20, 32'hCAFE_BABE, 1'b0);  // shamt 0

        // rol shamt 4
        issue(2'b10, 3'b000, 32'h8000_0001, 32'h0000_0024);
`ifndef RVX_FAST_ROT_EN
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rot_busy", 32'(busy), 32'd1);
            chk("rot_no_valid", 32'(out_valid), 32'd0);
            step();
        end
`endif
        @(negedge clk);
        chk("rol_valid", 32'(out_valid), 32'd1);
        chk("rol_result", result, 32'h0000_0018);
        step();

        // Backpressure in HOLD with a new op waiting
        out_ready = 1'b0;
        issue(2'b00, 3'b001, 32'h0F0F_1234, 32'h00FF_5678);
        f7 = 2'b00; f3 = 3'b010; a = 32'h1111_2222; b = 32'h3333_4444; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_busy", 32'(busy), 32'd1);
            step();
        end
        out_ready = 1'b1;
        issue(2'b00, 3'b010, 32'h1111_2222, 32'h3333_4444);
        step();

        // Flush in the second ROT cycle of ror shamt 31
        issue(2'b10, 3'b001, 32'h8765_4321, 32'h0000_001F);
        step();
        flush = 1'b1;
        q.delete();
        @(negedge clk);
        chk("flush_in_ready", 32'(in_ready), 32'd0);
        step();
        flush = 1'b0;
        @(negedge clk);
        chk("post_flush_valid", 32'(out_valid), 32'd0);
        chk("post_flush_busy", 32'(busy), 32'd0);
        chk("post_flush_in_ready", 32'(in_ready), 32'd1);
        for (int k = 0; k < 40; k++) step();

        // Reset while holding a result
        out_ready = 1'b0;
        issue(2'b01, 3'b011, 32'h0000_0005, 32'hFFFF_0000);
        step();
        reset_n = 1'b0;
        q.delete();
        @(negedge clk);
        chk("hold_rst_in_ready", 32'(in_ready), 32'd0);
        step();
        reset_n = 1'b1;
        @(negedge clk);
        chk("hold_rst_valid", 32'(out_valid), 32'd0);
        chk("hold_rst_result", result, 32'd0);
        chk("hold_rst_in_ready", 32'(in_ready), 32'd1);
        step();

        // Randomized traffic
        rand_rdy = 1'b1;
        for (int n = 0; n < 400; n++) begin
            idx  = $urandom_range(0, 10);
            code = (idx == 10) ? 5'($urandom) : tbl[idx];
            rb   = $urandom;
            if (code[4:3] == 2'b10 && $urandom_range(0, 1) == 0) rb[4:0] = 5'($urandom_range(0, 3));
            issue(code[4:3], code[2:0], $urandom, rb);
            if ($urandom_range(0, 39) == 0) do_flush();
            if ($urandom_range(0, 7) == 0) step();
        end

        // Drain
        rand_rdy = 1'b0;
        out_ready = 1'b1;
        for (int t = 0; t < 100 && q.size() != 0; t++) step();
        if (q.size() != 0) bound_fail("drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
